// File: rtl/phase_gen_pkg.sv
// Shared definitions for the phase generator: FSM encoding and default strobe windows.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package phase_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Reset windows: ch0 is the legacy ALU strobe, ch1 the legacy fetch strobe.
  localparam int DEF_CH0_START = 1;
  localparam int DEF_CH0_END   = 1;
  localparam int DEF_CH1_START = 3;
  localparam int DEF_CH1_END   = 6;

endpackage

// File: rtl/phase_gen_if.sv
// Control, configuration and strobe bundle between the phase generator and its user.
// Latency: n/a (wires only).
// Backpressure: none; stall is the only hold mechanism and it is a plain level.
interface phase_gen_if #(
  parameter int NPHASE = 8,
  parameter int NCH    = 2,
  parameter int PW     = $clog2(NPHASE),
  parameter int CW     = (NCH > 1) ? $clog2(NCH) : 1
) ();

  logic              en;
  logic              step_mode;
  logic              step_req;
  logic              stall;
  logic              cfg_we;
  logic [CW-1:0]     cfg_ch;
  logic [PW-1:0]     cfg_start;
  logic [PW-1:0]     cfg_end;
  logic              cfg_on;
  logic [PW-1:0]     phase_idx;
  logic [NPHASE-1:0] phase_oh;
  logic [NCH-1:0]    ch_out;
  logic              cycle_start;
  logic              cycle_end;
  logic              busy;

  // Controller side: drives run control and configuration, observes strobes.
  modport master (
    output en, step_mode, step_req, stall,
    output cfg_we, cfg_ch, cfg_start, cfg_end, cfg_on,
    input  phase_idx, phase_oh, ch_out, cycle_start, cycle_end, busy
  );

  // Generator side.
  modport slave (
    input  en, step_mode, step_req, stall,
    input  cfg_we, cfg_ch, cfg_start, cfg_end, cfg_on,
    output phase_idx, phase_oh, ch_out, cycle_start, cycle_end, busy
  );

endinterface

// File: rtl/phase_window_cmp.sv
// Wrap-aware phase window match: hit when phase p lies in [first..last] (wrapping if first > last).
// Latency: combinational.
// Backpressure: none.
module phase_window_cmp #(
  parameter int PW = 3
) (
  input  logic [PW-1:0] p,
  input  logic [PW-1:0] first,
  input  logic [PW-1:0] last,
  input  logic          on,
  output logic          hit
);

  // first > last means the window runs across the phase 0 boundary.
  always_comb begin
    hit = 1'b0;
    if (first <= last) begin
      hit = on && (p >= first) && (p <= last);
    end else begin
      hit = on && ((p >= first) || (p <= last));
    end
  end

endmodule

// File: rtl/phase_gen.sv
// Multi-channel phase generator: NPHASE-phase counter with NCH programmable strobe windows.
// Latency: start condition to phase 0 is one edge; all outputs registered, strobes aligned to phase_idx.
// Backpressure: stall freezes phase, strobes and flags; step_req while busy is dropped.
module phase_gen
  import phase_gen_pkg::*;
#(
  parameter int NPHASE = 8,
  parameter int NCH    = 2,
  parameter int PW     = $clog2(NPHASE),
  parameter int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic         clk,
  input logic         reset,
  phase_gen_if.slave  bus
);

  localparam logic [PW-1:0]     LAST   = PW'(NPHASE - 1);
  localparam logic [NPHASE-1:0] OH_ONE = NPHASE'(1);

  state_t             state_q, state_n;
  logic [PW-1:0]      phase_q, phase_n;
  logic               load_n;
  logic               run_n;

  logic [PW-1:0]      pend_start_q [NCH];
  logic [PW-1:0]      pend_end_q   [NCH];
  logic [NCH-1:0]     pend_on_q;
  logic [PW-1:0]      pend_start_n [NCH];
  logic [PW-1:0]      pend_end_n   [NCH];
  logic [NCH-1:0]     pend_on_n;

  logic [PW-1:0]      act_start_q  [NCH];
  logic [PW-1:0]      act_end_q    [NCH];
  logic [NCH-1:0]     act_on_q;
  logic [PW-1:0]      act_start_n  [NCH];
  logic [PW-1:0]      act_end_n    [NCH];
  logic [NCH-1:0]     act_on_n;

  logic [NCH-1:0]     hit_n;
  logic [NCH-1:0]     ch_q;
  logic [NPHASE-1:0]  oh_q;
  logic               cs_q;
  logic               ce_q;

  // Next state and phase; load_n marks every phase-0 entry, where the active windows refresh.
  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    load_n  = 1'b0;
    case (state_q)
      IDLE: begin
        phase_n = '0;
        if ((!bus.step_mode && bus.en) || (bus.step_mode && bus.step_req)) begin
          state_n = RUN;
          load_n  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (phase_q == LAST) begin
            phase_n = '0;
            if (!bus.step_mode && bus.en) begin
              load_n = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            phase_n = phase_q + PW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
  end

  assign run_n = (state_n == RUN);

  // Pending windows take writes at once; active windows copy them (write included) at phase-0 entry.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pend_start_n[i] = pend_start_q[i];
      pend_end_n[i]   = pend_end_q[i];
      pend_on_n[i]    = pend_on_q[i];
      if (bus.cfg_we && (bus.cfg_ch == CW'(i))) begin
        pend_start_n[i] = bus.cfg_start;
        pend_end_n[i]   = bus.cfg_end;
        pend_on_n[i]    = bus.cfg_on;
      end
      act_start_n[i] = load_n ? pend_start_n[i] : act_start_q[i];
      act_end_n[i]   = load_n ? pend_end_n[i]   : act_end_q[i];
      act_on_n[i]    = load_n ? pend_on_n[i]    : act_on_q[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_cmp
      phase_window_cmp #(.PW(PW)) u_cmp (
        .p     (phase_n),
        .first (act_start_n[g]),
        .last  (act_end_n[g]),
        .on    (act_on_n[g]),
        .hit   (hit_n[g])
      );
    end
  endgenerate

  // Window registers; reset restores the legacy ALU/fetch timing on ch0/ch1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        pend_start_q[i] <= (i == 0) ? PW'(DEF_CH0_START) : (i == 1) ? PW'(DEF_CH1_START) : '0;
        pend_end_q[i]   <= (i == 0) ? PW'(DEF_CH0_END)   : (i == 1) ? PW'(DEF_CH1_END)   : '0;
        pend_on_q[i]    <= (i < 2);
        act_start_q[i]  <= (i == 0) ? PW'(DEF_CH0_START) : (i == 1) ? PW'(DEF_CH1_START) : '0;
        act_end_q[i]    <= (i == 0) ? PW'(DEF_CH0_END)   : (i == 1) ? PW'(DEF_CH1_END)   : '0;
        act_on_q[i]     <= (i < 2);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pend_start_q[i] <= pend_start_n[i];
        pend_end_q[i]   <= pend_end_n[i];
        pend_on_q[i]    <= pend_on_n[i];
        act_start_q[i]  <= act_start_n[i];
        act_end_q[i]    <= act_end_n[i];
        act_on_q[i]     <= act_on_n[i];
      end
    end
  end

  // State, phase and outputs, all computed from next state so strobes line up with phase_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      ch_q    <= '0;
      oh_q    <= '0;
      cs_q    <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      ch_q    <= run_n ? hit_n : '0;
      oh_q    <= run_n ? (OH_ONE << phase_n) : '0;
      cs_q    <= run_n && (phase_n == '0);
      ce_q    <= run_n && (phase_n == LAST);
    end
  end

  assign bus.phase_idx   = phase_q;
  assign bus.phase_oh    = oh_q;
  assign bus.ch_out      = ch_q;
  assign bus.cycle_start = cs_q;
  assign bus.cycle_end   = ce_q;
  assign bus.busy        = (state_q == RUN);

endmodule
